// File: rtl/hdlc_tx_arbiter.sv
// Round-robin arbiter feeding two byte-stream requesters into the HDLC Tx register interface.
// state  | meaning
// IDLE   | no frame owned; waits for a request while Tx_Done=1
// LOAD   | streaming granted requester's bytes into Tx_Buff (excess bytes dropped)
// START  | issuing Tx_Enable
// SEND   | waiting for Tx_Done fall then rise; abort or timeout possible
// ABORT  | issuing Tx_AbortFrame
// ABWAIT | waiting for the HDLC core to confirm the abort
// DONE   | frame complete, releasing the grant
module hdlc_tx_arbiter #(
  parameter int MAX_BYTES      = 126,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Req0_Valid,
  input  logic [7:0] Req0_Data,
  input  logic       Req0_Last,
  output logic       Req0_Ready,
  input  logic       Req1_Valid,
  input  logic [7:0] Req1_Data,
  input  logic       Req1_Last,
  output logic       Req1_Ready,
  input  logic       Abort_Req,
  input  logic       Tx_Done,
  input  logic       Tx_AbortedTrans,
  output logic [2:0] Address,
  output logic       WriteEnable,
  output logic [7:0] DataIn,
  output logic [1:0] Grant,
  output logic       Busy,
  output logic       FrameSent,
  output logic       FrameAborted,
  output logic       Overrun
);

  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BYTES);
  localparam logic [TW-1:0] TMO     = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_SEND, S_ABORT, S_ABWAIT, S_DONE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   byte_cnt, byte_cnt_n;
  logic [TW-1:0]   timer, timer_n;
  logic            rr_last, rr_last_n;
  logic            seen_low, seen_low_n;
  logic [2:0]      addr_n;
  logic [7:0]      data_n;
  logic [1:0]      grant_n;
  logic            we_n, busy_n, sent_n, aborted_n, overrun_n, ready0_n, ready1_n;

  logic            sel_valid, sel_ready, sel_last, accept, pick1;
  logic [7:0]      sel_data;

  assign sel_valid = Grant[1] ? Req1_Valid : Req0_Valid;
  assign sel_ready = Grant[1] ? Req1_Ready : Req0_Ready;
  assign sel_last  = Grant[1] ? Req1_Last  : Req0_Last;
  assign sel_data  = Grant[1] ? Req1_Data  : Req0_Data;
  assign accept    = (state == S_LOAD) && sel_valid && sel_ready;
  // Requester 1 wins when it is the only one asking or when requester 0 was served last.
  assign pick1     = Req1_Valid && (!Req0_Valid || !rr_last);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state        <= S_IDLE;
      byte_cnt     <= '0;
      timer        <= '0;
      rr_last      <= 1'b1;
      seen_low     <= 1'b0;
      Address      <= '0;
      WriteEnable  <= 1'b0;
      DataIn       <= '0;
      Grant        <= '0;
      Busy         <= 1'b0;
      FrameSent    <= 1'b0;
      FrameAborted <= 1'b0;
      Overrun      <= 1'b0;
      Req0_Ready   <= 1'b0;
      Req1_Ready   <= 1'b0;
    end else begin
      state        <= state_n;
      byte_cnt     <= byte_cnt_n;
      timer        <= timer_n;
      rr_last      <= rr_last_n;
      seen_low     <= seen_low_n;
      Address      <= addr_n;
      WriteEnable  <= we_n;
      DataIn       <= data_n;
      Grant        <= grant_n;
      Busy         <= busy_n;
      FrameSent    <= sent_n;
      FrameAborted <= aborted_n;
      Overrun      <= overrun_n;
      Req0_Ready   <= ready0_n;
      Req1_Ready   <= ready1_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if ((Req0_Valid || Req1_Valid) && Tx_Done) state_n = S_LOAD;
      S_LOAD:   if (accept && sel_last) state_n = S_START;
      S_START:  state_n = S_SEND;
      S_SEND: begin
        if (Abort_Req || timer == TMO) state_n = S_ABORT;
        else if (seen_low && Tx_Done)  state_n = S_DONE;
      end
      S_ABORT:  state_n = S_ABWAIT;
      S_ABWAIT: if (Tx_AbortedTrans || Tx_Done) state_n = S_IDLE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    grant_n    = Grant;
    we_n       = 1'b0;
    addr_n     = Address;
    data_n     = DataIn;
    sent_n     = 1'b0;
    aborted_n  = 1'b0;
    overrun_n  = 1'b0;
    byte_cnt_n = byte_cnt;
    timer_n    = '0;
    seen_low_n = 1'b0;
    rr_last_n  = rr_last;
    case (state)
      S_IDLE: begin
        if (state_n == S_LOAD) begin
          grant_n   = pick1 ? 2'b10 : 2'b01;
          rr_last_n = pick1;
        end
      end
      S_LOAD: begin
        if (accept && byte_cnt < CNT_MAX) begin
          we_n       = 1'b1;
          addr_n     = 3'd1;
          data_n     = sel_data;
          byte_cnt_n = byte_cnt + 1'b1;
          if (!sel_last && byte_cnt == CNT_MAX - 1'b1) overrun_n = 1'b1;
        end
      end
      S_START: begin
        we_n   = 1'b1;
        addr_n = 3'd0;
        data_n = 8'h02;
      end
      S_SEND: begin
        timer_n    = timer + 1'b1;
        seen_low_n = seen_low | ~Tx_Done;
        if (state_n == S_ABORT) begin
          we_n   = 1'b1;
          addr_n = 3'd0;
          data_n = 8'h04;
        end else if (state_n == S_DONE) begin
          sent_n = 1'b1;
        end
      end
      S_ABWAIT: begin
        if (state_n == S_IDLE) begin
          aborted_n  = 1'b1;
          grant_n    = '0;
          byte_cnt_n = '0;
        end
      end
      S_DONE: begin
        grant_n    = '0;
        byte_cnt_n = '0;
      end
      default: ;
    endcase
    busy_n   = (state_n != S_IDLE);
    ready0_n = (state_n == S_LOAD) && grant_n[0];
    ready1_n = (state_n == S_LOAD) && grant_n[1];
  end

endmodule

// File: tb/tb_hdlc_tx_arbiter.sv
// Directed and randomized frames against a frame-level model of the expected HDLC bus writes.
module tb_hdlc_tx_arbiter;
  localparam int MAXB = 126;
  localparam int TMO  = 16;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Req0_Valid, Req0_Last, Req0_Ready;
  logic [7:0] Req0_Data;
  logic       Req1_Valid, Req1_Last, Req1_Ready;
  logic [7:0] Req1_Data;
  logic       Abort_Req, Tx_Done, Tx_AbortedTrans;
  logic [2:0] Address;
  logic       WriteEnable;
  logic [7:0] DataIn;
  logic [1:0] Grant;
  logic       Busy, FrameSent, FrameAborted, Overrun;

  hdlc_tx_arbiter #(.MAX_BYTES(MAXB), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk(Clk), .Rst(Rst),
    .Req0_Valid(Req0_Valid), .Req0_Data(Req0_Data), .Req0_Last(Req0_Last), .Req0_Ready(Req0_Ready),
    .Req1_Valid(Req1_Valid), .Req1_Data(Req1_Data), .Req1_Last(Req1_Last), .Req1_Ready(Req1_Ready),
    .Abort_Req(Abort_Req), .Tx_Done(Tx_Done), .Tx_AbortedTrans(Tx_AbortedTrans),
    .Address(Address), .WriteEnable(WriteEnable), .DataIn(DataIn),
    .Grant(Grant), .Busy(Busy), .FrameSent(FrameSent), .FrameAborted(FrameAborted),
    .Overrun(Overrun)
  );

  always #5 Clk = ~Clk;

  int          checks = 0;
  int          errors = 0;
  int          n_sent = 0, n_abort = 0, n_ovr = 0;
  int          tx_lat = 8;
  logic [12:0] wq[$];
  logic [12:0] eq[$];
  logic [7:0]  fdata [2][256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor and pulse counters.
  initial forever begin
    @(negedge Clk);
    if (WriteEnable) wq.push_back({Grant, Address, DataIn});
    if (FrameSent)    n_sent++;
    if (FrameAborted) n_abort++;
    if (Overrun)      n_ovr++;
    chk("ready_owner", {30'd0, Req0_Ready & ~Grant[0], Req1_Ready & ~Grant[1]}, 0);
  end

  // HDLC core model: Tx_Done falls after Tx_Enable, rises after tx_lat cycles unless aborted.
  initial begin
    bit ab;
    Tx_Done = 1'b1;
    Tx_AbortedTrans = 1'b0;
    forever begin
      @(negedge Clk);
      if (WriteEnable && Address == 3'd0 && DataIn == 8'h02) begin
        repeat (2) @(negedge Clk);
        Tx_Done = 1'b0;
        ab = 1'b0;
        for (int i = 0; i < tx_lat && !ab; i++) begin
          @(negedge Clk);
          if (WriteEnable && Address == 3'd0 && DataIn == 8'h04) ab = 1'b1;
        end
        if (ab) begin
          @(negedge Clk);
          Tx_AbortedTrans = 1'b1;
          Tx_Done = 1'b1;
          @(negedge Clk);
          Tx_AbortedTrans = 1'b0;
        end else begin
          Tx_Done = 1'b1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] gr(input int r);
    return (r == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic fill(input int r, input int base, input int n);
    for (int i = 0; i < n; i++) fdata[r][base+i] = 8'($urandom);
  endtask

  task automatic expect_frame(input int r, input int base, input int n, input bit aborted);
    int k = (n < MAXB) ? n : MAXB;
    for (int i = 0; i < k; i++) eq.push_back({gr(r), 3'd1, fdata[r][base+i]});
    eq.push_back({gr(r), 3'd0, 8'h02});
    if (aborted) eq.push_back({gr(r), 3'd0, 8'h04});
  endtask

  task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic l);
    if (r == 0) begin Req0_Valid = v; Req0_Data = d; Req0_Last = l; end
    else        begin Req1_Valid = v; Req1_Data = d; Req1_Last = l; end
  endtask

  // Presents bytes one per cycle; a byte is taken at the next posedge when Ready is already high.
  task automatic drive(input int r, input int base, input int n, input int stop);
    int i = 0;
    int guard = 0;
    logic rdy;
    while (i < n && i < stop && guard < 2000) begin
      @(negedge Clk);
      guard++;
      set_req(r, 1'b1, fdata[r][base+i], (i == n - 1));
      rdy = (r == 0) ? Req0_Ready : Req1_Ready;
      if (rdy) i++;
    end
    chk("drive_guard", {31'd0, guard < 2000}, 1);
    @(negedge Clk);
    set_req(r, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (Busy !== 1'b0 && g < 3000) begin
      @(negedge Clk);
      g++;
    end
    chk("idle_wait", {31'd0, Busy}, 0);
    @(negedge Clk);
  endtask

  task automatic wait_write(input logic [7:0] d, output int g);
    g = 0;
    do begin
      @(negedge Clk);
      g++;
    end while (!(WriteEnable && Address == 3'd0 && DataIn == d) && g < 200);
    chk($sformatf("ctrl_write_%0h_seen", d), {31'd0, g < 200}, 1);
  endtask

  task automatic check_writes();
    chk("n_writes", wq.size(), eq.size());
    for (int i = 0; i < eq.size() && i < wq.size(); i++)
      chk($sformatf("write%0d", i), {19'd0, wq[i]}, {19'd0, eq[i]});
    wq.delete();
    eq.delete();
  endtask

  initial begin
    int s0, a0, o0, g, r, n, last_owner, owner;
    int pend[2];
    int idx[2];
    Rst = 1'b0;
    Abort_Req = 1'b0;
    set_req(0, 1'b0, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge Clk);
    chk("reset_outputs", {12'd0, Req0_Ready, Req1_Ready, Address, WriteEnable, DataIn, Grant,
                          Busy, FrameSent, FrameAborted, Overrun}, 0);
    Rst = 1'b1;
    @(negedge Clk);

    // Both requesters continuously valid, two 2-byte frames each.
    fill(0, 0, 4);
    fill(1, 0, 4);
    s0 = n_sent;
    fork
      begin drive(0, 0, 2, 1000); drive(0, 2, 2, 1000); end
      begin drive(1, 0, 2, 1000); drive(1, 2, 2, 1000); end
    join
    wait_idle();
    pend = '{2, 2};
    idx  = '{0, 0};
    last_owner = 1;
    for (int f = 0; f < 4; f++) begin
      if (pend[0] > 0 && pend[1] > 0) owner = 1 - last_owner;
      else owner = (pend[0] > 0) ? 0 : 1;
      expect_frame(owner, idx[owner] * 2, 2, 1'b0);
      idx[owner]++;
      pend[owner]--;
      last_owner = owner;
    end
    if (wq.size() > 0) chk("first_grant", {30'd0, wq[0][12:11]}, 2'b01);
    else chk("first_grant_present", wq.size(), 1);
    check_writes();
    chk("rr_sent", n_sent - s0, 4);

    // Directed 3-byte frame from requester 0.
    fdata[0][0] = 8'hA1;
    fdata[0][1] = 8'hB2;
    fdata[0][2] = 8'hC3;
    s0 = n_sent;
    drive(0, 0, 3, 1000);
    wait_idle();
    expect_frame(0, 0, 3, 1'b0);
    check_writes();
    chk("abc_sent", n_sent - s0, 1);
    chk("abc_grant_released", {30'd0, Grant}, 0);

    // Randomized single-requester frames.
    for (int f = 0; f < 4; f++) begin
      r = $urandom_range(0, 1);
      n = $urandom_range(1, 12);
      fill(r, 0, n);
      s0 = n_sent;
      drive(r, 0, n, 1000);
      wait_idle();
      expect_frame(r, 0, n, 1'b0);
      check_writes();
      chk($sformatf("rand%0d_sent", f), n_sent - s0, 1);
    end

    // Oversized frame from requester 1 is truncated.
    fill(1, 0, 130);
    s0 = n_sent;
    o0 = n_ovr;
    drive(1, 0, 130, 1000);
    wait_idle();
    expect_frame(1, 0, 130, 1'b0);
    check_writes();
    chk("ovr_pulses", n_ovr - o0, 1);
    chk("ovr_sent", n_sent - s0, 1);

    // Abort request five cycles into SEND.
    fill(0, 0, 4);
    s0 = n_sent;
    a0 = n_abort;
    drive(0, 0, 4, 1000);
    wait_write(8'h02, g);
    repeat (5) @(negedge Clk);
    Abort_Req = 1'b1;
    @(negedge Clk);
    chk("abort_write_next", {20'd0, WriteEnable, Address, DataIn}, {20'd0, 1'b1, 3'd0, 8'h04});
    Abort_Req = 1'b0;
    wait_idle();
    expect_frame(0, 0, 4, 1'b1);
    check_writes();
    chk("abort_pulses", n_abort - a0, 1);
    chk("abort_no_sent", n_sent - s0, 0);

    // Tx_Done stuck low forces a timeout abort.
    tx_lat = 1000;
    fill(0, 0, 3);
    s0 = n_sent;
    a0 = n_abort;
    drive(0, 0, 3, 1000);
    wait_write(8'h02, g);
    wait_write(8'h04, g);
    chk("timeout_delay", g, TMO + 1);
    wait_idle();
    expect_frame(0, 0, 3, 1'b1);
    check_writes();
    chk("timeout_aborted", n_abort - a0, 1);
    chk("timeout_no_sent", n_sent - s0, 0);
    tx_lat = 8;

    // Reset mid-LOAD, then a full-size frame must not overrun.
    fill(0, 0, 20);
    drive(0, 0, 20, 10);
    #2;
    Rst = 1'b0;
    #1;
    chk("async_reset_outputs", {12'd0, Req0_Ready, Req1_Ready, Address, WriteEnable, DataIn, Grant,
                                Busy, FrameSent, FrameAborted, Overrun}, 0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    wq.delete();
    eq.delete();
    fill(0, 0, MAXB);
    s0 = n_sent;
    o0 = n_ovr;
    drive(0, 0, MAXB, 1000);
    wait_idle();
    expect_frame(0, 0, MAXB, 1'b0);
    check_writes();
    chk("post_reset_no_ovr", n_ovr - o0, 0);
    chk("post_reset_sent", n_sent - s0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
